wave_capture: RTL and testbench

WAVE_CAPTURE -- requirements
Module: wave_capture

---
 rtl/wave_capture_pkg.sv | 22 ++
 rtl/wave_capture_trig.sv | 26 ++
 rtl/wave_capture.sv | 97 +++++++++
 tb/tb_wave_capture.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wave_capture_pkg.sv
// Shared types and constants for the wave_capture trigger/capture slice.
// The optional ARMED timeout is enabled with WAVE_CAPTURE_TIMEOUT_EN.
package wave_capture_pkg;

    localparam int SAMPLE_W                = 16;
    localparam int ADDR_W                  = 9;
    localparam int CAPTURE_LEN             = 256;
    localparam int COUNT_W                 = $clog2(CAPTURE_LEN);
    localparam int TIMEOUT_SAMPLES_DEFAULT = 4096;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Signed high byte to offset-binary display byte.
    function automatic logic [7:0] to_display(input logic [7:0] hi);
        return {~hi[7], hi[6:0]};
    endfunction

endpackage

// File: rtl/wave_capture_trig.sv
// Previous-sample register and positive zero-crossing detector.
// Built the same way with or without WAVE_CAPTURE_TIMEOUT_EN.
module wave_capture_trig
    import wave_capture_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_strobe,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W-1:0] prev_sample,
    output logic                crossing
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sample <= '0;
        end else if (sample_strobe) begin
            prev_sample <= sample;
        end
    end

    assign crossing = sample_strobe
                    & prev_sample[SAMPLE_W-1]
                    & ~sample[SAMPLE_W-1];

endmodule

// File: rtl/wave_capture.sv
// Triggered capture of 256 samples into the idle half of a display RAM.
// Define WAVE_CAPTURE_TIMEOUT_EN to force a trigger after TIMEOUT_SAMPLES.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int TIMEOUT_SAMPLES = TIMEOUT_SAMPLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    output logic [ADDR_W-1:0]   write_address,
    output logic                write_enable,
    output logic [7:0]          write_sample,
    output logic                read_index
);

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic               crossing;

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
    logic [TW-1:0] tcnt;
`endif

    wave_capture_trig u_trig (
        .clk           (clk),
        .reset         (reset),
        .sample_strobe (new_sample_ready),
        .sample        (new_sample_in),
        .prev_sample   (),
        .crossing      (crossing)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ARMED;
            count         <= '0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
            tcnt          <= '0;
`endif
        end else begin
            write_enable <= 1'b0;
            unique case (state)
                ARMED: begin
                    if (crossing) begin
                        state <= ACTIVE;
                        count <= '0;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end
`ifdef WAVE_CAPTURE_TIMEOUT_EN
                    else if (new_sample_ready) begin
                        if (tcnt == TW'(TIMEOUT_SAMPLES - 1)) begin
                            state <= ACTIVE;
                            count <= '0;
                            tcnt  <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
`endif
                end
                ACTIVE: begin
                    if (new_sample_ready) begin
                        write_enable  <= 1'b1;
                        write_address <= {~read_index, count};
                        write_sample  <= to_display(new_sample_in[15:8]);
                        count         <= count + 1'b1;
                        if (count == COUNT_W'(CAPTURE_LEN - 1)) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Swap halves only once the display is off the waveform.
                    if (wave_display_idle) begin
                        read_index <= ~read_index;
                        state      <= ARMED;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
                        tcnt       <= '0;
`endif
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
// Scoreboard bench for wave_capture: expected RAM writes are queued by the
// stimulus and popped by an independent write-port monitor.
module tb_wave_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_sample_ready = 1'b0;
    logic [15:0] new_sample_in = '0;
    logic        wave_display_idle = 1'b0;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int checks = 0;
    int failures = 0;
    logic [16:0] exp_q[$];

    wave_capture #(.TIMEOUT_SAMPLES(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    always #5 clk = ~clk;

    // Monitor: every observed write must match the head of the queue.
    always @(negedge clk) begin
        if (reset === 1'b1 && write_enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h",
                         write_address, write_sample);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({write_address, write_sample} !== e) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                             write_address, write_sample, e[16:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [8:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send(input logic [15:0] s, input logic idle = 1'b0);
        @(posedge clk);
        #1;
        new_sample_in     = s;
        new_sample_ready  = 1'b1;
        wave_display_idle = idle;
        @(posedge clk);
        #1;
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
    endtask

    task automatic idle_pulse();
        @(posedge clk);
        #1 wave_display_idle = 1'b1;
        @(posedge clk);
        #1 wave_display_idle = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_%s pending=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_we"}, 16'(write_enable), 16'h0);
        chk({name, "_addr"}, 16'(write_address), 16'h0);
        chk({name, "_data"}, 16'(write_sample), 16'h0);
        chk({name, "_ridx"}, 16'(read_index), 16'h0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 reset = 1'b0;
        #2 check_zero("reset");
        release_reset();

        // Positive-only input: no trigger unless the timeout is built in.
        for (int k = 1; k <= 20; k++) begin
`ifdef WAVE_CAPTURE_TIMEOUT_EN
            if (k > 16) push(9'h100 + 9'(k - 17), 8'(k) ^ 8'h80);
`endif
            send(16'(k << 8));
        end
        drain("positive");
        @(posedge clk);
        #2 reset = 1'b0;
        release_reset();

        // Trigger on -1 -> 0, then a 256-sample ramp into the upper half.
        send(16'hFFFF);
        send(16'h0000);
        for (int i = 1; i <= 256; i++) begin
            push(9'h100 + 9'(i - 1), 8'(i) ^ 8'h80);
            send(16'(i << 8));
        end
        drain("ramp");

        // In WAIT: crossings are ignored, no idle yet.
        send(16'hFFFF);
        send(16'h0000);
        send(16'hFFFF);
        drain("wait_ignore");
        chk("ridx_before_idle", 16'(read_index), 16'h0);

        // Exit with a crossing strobe in the same cycle: must not trigger.
        send(16'h0000, 1'b1);
        chk("ridx_after_idle", 16'(read_index), 16'h1);
        idle_pulse();
        idle_pulse();
        send(16'h0100);
        drain("armed_idle");
        chk("ridx_single_toggle", 16'(read_index), 16'h1);

        // Second capture lands in the lower half; endpoint conversions.
        send(16'h8000);
        send(16'h0000);
        push(9'h000, 8'h00);
        send(16'h8000);
        push(9'h001, 8'h80);
        send(16'h0000);
        push(9'h002, 8'hFF);
        send(16'h7FFF);
        for (int i = 3; i <= 255; i++) begin
            push(9'(i), 8'(i) ^ 8'h80);
            send(16'(i << 8));
        end
        drain("lower_half");
        send(16'hFFFF);
        send(16'h0000);
        drain("wait2_ignore");
        chk("ridx_wait2", 16'(read_index), 16'h1);

        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_zero("reset_wait");
        release_reset();

        // 100 writes, then reset lands while a write strobe is live.
        send(16'hFFFF);
        send(16'h0000);
        for (int i = 0; i < 100; i++) begin
            push(9'h100 + 9'(i), 8'(i + 1) ^ 8'h80);
            send(16'((i + 1) << 8));
        end
        drain("partial");
        @(posedge clk);
        #1;
        new_sample_in    = 16'h4000;
        new_sample_ready = 1'b1;
        @(posedge clk);
        #1 new_sample_ready = 1'b0;
        chk("we_live", 16'(write_enable), 16'h1);
        reset = 1'b0;
        #1 check_zero("reset_active");
        release_reset();

        // Fresh capture restarts at the base of the upper half.
        send(16'hFFFF);
        send(16'h0000);
        push(9'h100, 8'h90);
        send(16'h1000);
        push(9'h101, 8'h60);
        send(16'hE000);
        push(9'h102, 8'hC0);
        send(16'h4000);
        drain("restart");

        repeat (10) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
